pyramid_sequencer: RTL

- Controller that builds the SIFT octave pyramid by repeatedly driving the shared image_half downsampler.
- For each octave k = 1..NUM_OCTAVES-1, it raster-reads octave k-1 from the pyramid buffer and streams the pixels with x/y coordinates into image_half.
- It collects image_half's output and writes it into octave k of the buffer.
- It sits between the pyramid BRAM and the image_half instances, upstream of the blur/DoG stages.

---
 rtl/pyramid_pkg.sv | 25 ++
 rtl/pyramid_sequencer_tag_delay.sv | 35 +++
 rtl/pyramid_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pyramid_pkg.sv
// Shared definitions for the SIFT octave pyramid sequencer.
// Holds the FSM state encoding and the octave geometry helpers.
package pyramid_pkg;

  typedef logic [2:0] pyr_state_t;

  localparam pyr_state_t StIdle   = 3'd0;
  localparam pyr_state_t StRead   = 3'd1;
  localparam pyr_state_t StDrain  = 3'd2;
  localparam pyr_state_t StNext   = 3'd3;
  localparam pyr_state_t StFinish = 3'd4;

  // Edge length of octave k.
  function automatic int unsigned octave_width(input int unsigned top_width,
                                               input int unsigned k);
    return top_width >> k;
  endfunction

  // Pixel count of octave k; the square is folded into a constant so only a shift remains.
  function automatic int unsigned octave_pixels(input int unsigned top_width,
                                                input int unsigned k);
    return (top_width * top_width) >> (2 * k);
  endfunction

endpackage

// File: rtl/pyramid_sequencer_tag_delay.sv
// Fixed-depth shift register that carries the valid/x/y tags of a pyramid-buffer read
// alongside the BRAM latency, so the tags leave exactly when the read data arrives.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-low reset, flushes every stage
//   tag_in  - tag entering the pipe this cycle
//   tag_out - tag entered DEPTH cycles ago
module pyramid_sequencer_tag_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign tag_out = r_stage[DEPTH-1];

endmodule

// File: rtl/pyramid_sequencer.sv
// Builds the SIFT octave pyramid: for each octave k = 1..NUM_OCTAVES-1 it raster-reads
// octave k-1 from the pyramid buffer, streams the pixels with coordinates into image_half,
// and writes image_half's results back into octave k.
// Ports:
//   clk_in, rst_in            - clock, synchronous active-low reset
//   start_in                  - pulse to begin construction (honoured only when idle)
//   busy_out, done_out        - run in progress / one-cycle completion pulse
//   rd_addr_out/octave/en     - source read request (address y*W + x in octave k-1)
//   rd_data_in                - read data, BRAM_LATENCY cycles after rd_en_out
//   half_data/x/y/valid_out   - pixel stream towards image_half
//   half_octave_out           - target octave k, selects the image_half instance
//   half_data/addr/valid_in   - image_half results
//   wr_addr/octave/data/en    - registered write of those results into octave k
module pyramid_sequencer
  import pyramid_pkg::*;
#(
  parameter int unsigned BIT_DEPTH    = 8,
  parameter int unsigned TOP_WIDTH    = 64,
  parameter int unsigned NUM_OCTAVES  = 3,
  parameter int unsigned BRAM_LATENCY = 2,
  localparam int unsigned XW     = $clog2(TOP_WIDTH),
  localparam int unsigned ADDR_W = 2 * XW,
  localparam int unsigned OW     = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [ADDR_W-1:0]    rd_addr_out,
  output logic [OW-1:0]        rd_octave_out,
  output logic                 rd_en_out,
  input  logic [BIT_DEPTH-1:0] rd_data_in,
  output logic [BIT_DEPTH-1:0] half_data_out,
  output logic [XW-1:0]        half_x_out,
  output logic [XW-1:0]        half_y_out,
  output logic                 half_valid_out,
  output logic [OW-1:0]        half_octave_out,
  input  logic [BIT_DEPTH-1:0] half_data_in,
  input  logic [ADDR_W-3:0]    half_addr_in,
  input  logic                 half_valid_in,
  output logic [ADDR_W-1:0]    wr_addr_out,
  output logic [OW-1:0]        wr_octave_out,
  output logic [BIT_DEPTH-1:0] wr_data_out,
  output logic                 wr_en_out
);

  localparam int unsigned SW = $clog2(XW + 2);
  localparam int unsigned TW = 1 + 2 * XW;

  pyr_state_t          r_state, w_state_next;
  logic [OW-1:0]       r_k;
  logic [XW-1:0]       r_x, r_y;
  logic [ADDR_W-1:0]   r_wcnt;
  logic                r_wr_en;
  logic [BIT_DEPTH-1:0] r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [OW-1:0]       r_wr_octave;

  logic [XW-1:0]       w_wmax;
  logic [ADDR_W-1:0]   w_wtarget;
  logic [SW-1:0]       w_shift;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_rd_en;
  logic                w_last_oct;
  logic                w_wr_accept;
  logic [TW-1:0]       w_tag_in, w_tag_out;

  // Source octave k-1 has width TOP_WIDTH>>(k-1); its row stride is a shift by XW-k+1.
  always_comb begin
    w_wmax    = XW'(octave_width(TOP_WIDTH, 32'(r_k) - 32'd1) - 32'd1);
    w_wtarget = ADDR_W'(octave_pixels(TOP_WIDTH, 32'(r_k)));
    w_shift   = SW'(32'(XW) + 32'd1 - 32'(r_k));
    w_rd_addr = (ADDR_W'(r_y) << w_shift) + ADDR_W'(r_x);
  end

  assign w_rd_en     = (r_state == StRead);
  assign w_last_oct  = (32'(r_k) == NUM_OCTAVES - 1);
  assign w_wr_accept = half_valid_in && ((r_state == StRead) || (r_state == StDrain));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_in) w_state_next = (NUM_OCTAVES == 1) ? StFinish : StRead;
      end
      StRead: begin
        if ((r_x == w_wmax) && (r_y == w_wmax)) w_state_next = StDrain;
      end
      StDrain: begin
        if (r_wcnt >= w_wtarget) w_state_next = w_last_oct ? StFinish : StNext;
      end
      StNext:   w_state_next = StRead;
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_wcnt      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_octave <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (start_in) begin
            r_k    <= (NUM_OCTAVES == 1) ? OW'(0) : OW'(1);
            r_x    <= '0;
            r_y    <= '0;
            r_wcnt <= '0;
          end
        end
        StRead: begin
          if (r_x == w_wmax) begin
            r_x <= '0;
            r_y <= r_y + XW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        StNext: begin
          r_k    <= r_k + OW'(1);
          r_x    <= '0;
          r_y    <= '0;
          r_wcnt <= '0;
        end
        default: ;
      endcase

      // Results outside READ/DRAIN belong to no octave and are dropped.
      r_wr_en <= w_wr_accept;
      if (w_wr_accept) begin
        r_wcnt      <= r_wcnt + ADDR_W'(1);
        r_wr_data   <= half_data_in;
        r_wr_addr   <= ADDR_W'(half_addr_in);
        r_wr_octave <= r_k;
      end
    end
  end

  assign w_tag_in = {w_rd_en, r_x, r_y};

  pyramid_sequencer_tag_delay #(
    .DEPTH(BRAM_LATENCY),
    .WIDTH(TW)
  ) u_tag_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tag_in (w_tag_in),
    .tag_out(w_tag_out)
  );

  assign half_valid_out  = w_tag_out[2*XW];
  assign half_x_out      = w_tag_out[2*XW-1:XW];
  assign half_y_out      = w_tag_out[XW-1:0];
  assign half_data_out   = half_valid_out ? rd_data_in : '0;
  assign half_octave_out = r_k;

  assign rd_en_out     = w_rd_en;
  assign rd_addr_out   = w_rd_en ? w_rd_addr : '0;
  assign rd_octave_out = w_rd_en ? (r_k - OW'(1)) : '0;

  assign wr_en_out     = r_wr_en;
  assign wr_data_out   = r_wr_data;
  assign wr_addr_out   = r_wr_addr;
  assign wr_octave_out = r_wr_octave;

  assign busy_out = (r_state == StRead) || (r_state == StDrain) || (r_state == StNext);
  assign done_out = (r_state == StFinish);

endmodule
